// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors game: move and result codes,
// round-sequencer state encoding and the move judge.
package rps_pkg;

   localparam logic [1:0] ROCK     = 2'b00;
   localparam logic [1:0] PAPER    = 2'b01;
   localparam logic [1:0] SCISSORS = 2'b10;
   localparam logic [1:0] INVALID  = 2'b11;

   localparam logic [1:0] RES_ERR = 2'b00;
   localparam logic [1:0] RES_P1  = 2'b01;
   localparam logic [1:0] RES_P2  = 2'b10;
   localparam logic [1:0] RES_TIE = 2'b11;

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_REVEAL  = 2'd1;
   localparam logic [1:0] ST_SCORE   = 2'd2;
   localparam logic [1:0] ST_SHOW    = 2'd3;

   // An invalid move on either side voids the round rather than forfeiting it.
   function automatic logic [1:0] rps_judge(input logic [1:0] m1, input logic [1:0] m2);
      if (m1 == INVALID || m2 == INVALID) begin
         return RES_ERR;
      end else if (m1 == m2) begin
         return RES_TIE;
      end else if ((m1 == ROCK && m2 == SCISSORS) ||
                   (m1 == SCISSORS && m2 == PAPER) ||
                   (m1 == PAPER && m2 == ROCK)) begin
         return RES_P1;
      end else begin
         return RES_P2;
      end
   endfunction

endpackage

// File: rtl/rps_judge_comb.sv
// Pure combinational round judge, shared with the suspense display.
module rps_judge_comb
   import rps_pkg::*;
(
   input  logic [1:0] m1,
   input  logic [1:0] m2,
   output logic [1:0] res
);

   assign res = rps_judge(m1, m2);

endmodule

// File: rtl/rps_round_ctrl.sv
// Round sequencer: collects both locked moves, runs the reveal window against
// the display timebase, scores the round and tracks the match winner.
module rps_round_ctrl
   import rps_pkg::*;
#(
   parameter int REVEAL_TICKS = 1600,
   parameter int WIN_SCORE    = 3,
   parameter int CNT_W        = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [1:0] sw_move1,
   input  logic [1:0] sw_move2,
   input  logic       lock1,
   input  logic       lock2,
   input  logic       next,
   output logic [1:0] move1,
   output logic [1:0] move2,
   output logic [1:0] result,
   output logic       susp_en,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [1:0] locked,
   output logic       match_over
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REVEAL_TICKS - 1);
   localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       judged;

   rps_judge_comb u_judge (
      .m1  (move1),
      .m2  (move2),
      .res (judged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_COLLECT;
         cnt        <= '0;
         move1      <= ROCK;
         move2      <= ROCK;
         result     <= RES_ERR;
         susp_en    <= 1'b0;
         score1     <= '0;
         score2     <= '0;
         locked     <= 2'b00;
         match_over <= 1'b0;
      end else begin
         // Result tracks the latched moves one clock later in every state.
         result <= judged;
         case (state)
            ST_COLLECT: begin
               if (locked == 2'b11) begin
                  state   <= ST_REVEAL;
                  cnt     <= '0;
                  susp_en <= 1'b1;
               end else begin
                  if (lock1 && !locked[0]) begin
                     move1     <= sw_move1;
                     locked[0] <= 1'b1;
                  end
                  if (lock2 && !locked[1]) begin
                     move2     <= sw_move2;
                     locked[1] <= 1'b1;
                  end
               end
            end
            ST_REVEAL: begin
               if (tick) begin
                  if (cnt == CNT_LAST) begin
                     state <= ST_SCORE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_SCORE: begin
               state <= ST_SHOW;
               if (result == RES_P1) begin
                  score1 <= score1 + 4'd1;
                  if (score1 + 4'd1 == WIN) match_over <= 1'b1;
               end else if (result == RES_P2) begin
                  score2 <= score2 + 4'd1;
                  if (score2 + 4'd1 == WIN) match_over <= 1'b1;
               end
            end
            ST_SHOW: begin
               if (next) begin
                  if (match_over) begin
                     score1     <= '0;
                     score2     <= '0;
                     match_over <= 1'b0;
                  end
                  locked  <= 2'b00;
                  susp_en <= 1'b0;
                  move1   <= ROCK;
                  move2   <= ROCK;
                  state   <= ST_COLLECT;
               end
            end
            default: state <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: directed game scenarios plus randomized rounds,
// checked every cycle against a round-level model of the game.
module tb_rps_round_ctrl;

   localparam int REVEAL_TICKS = 1600;
   localparam int WIN_SCORE    = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick, lock1, lock2, next;
   logic [1:0] sw_move1, sw_move2;
   logic [1:0] move1, move2, result, locked;
   logic       susp_en, match_over;
   logic [3:0] score1, score2;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   rps_round_ctrl #(.REVEAL_TICKS(REVEAL_TICKS), .WIN_SCORE(WIN_SCORE), .CNT_W(11)) dut (
      .clk(clk), .rst(rst), .tick(tick),
      .sw_move1(sw_move1), .sw_move2(sw_move2),
      .lock1(lock1), .lock2(lock2), .next(next),
      .move1(move1), .move2(move2), .result(result), .susp_en(susp_en),
      .score1(score1), .score2(score2), .locked(locked), .match_over(match_over)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef enum {M_COLLECT, M_REVEAL, M_SCORE, M_SHOW} mph_t;
   mph_t m_ph;
   int   m_ticks;
   int   e_m1, e_m2, e_res, e_s1, e_s2, e_lk1, e_lk2, e_susp, e_mo;

   // Rock=0, paper=1, scissors=2: the move one step "ahead" mod 3 wins.
   function automatic int model_judge(input int a, input int b);
      if (a == 3 || b == 3) return 0;
      if (a == b) return 3;
      return (((a - b + 3) % 3) == 1) ? 1 : 2;
   endfunction

   always @(posedge clk or posedge rst) begin
      int old_m1, old_m2;
      if (rst) begin
         m_ph = M_COLLECT; m_ticks = 0;
         e_m1 = 0; e_m2 = 0; e_res = 0; e_s1 = 0; e_s2 = 0;
         e_lk1 = 0; e_lk2 = 0; e_susp = 0; e_mo = 0;
      end else begin
         old_m1 = e_m1;
         old_m2 = e_m2;
         case (m_ph)
            M_COLLECT: begin
               if (e_lk1 == 1 && e_lk2 == 1) begin
                  m_ph = M_REVEAL; m_ticks = 0; e_susp = 1;
               end else begin
                  if (lock1 && e_lk1 == 0) begin e_m1 = int'(sw_move1); e_lk1 = 1; end
                  if (lock2 && e_lk2 == 0) begin e_m2 = int'(sw_move2); e_lk2 = 1; end
               end
            end
            M_REVEAL: begin
               if (tick) m_ticks++;
               if (m_ticks == REVEAL_TICKS) m_ph = M_SCORE;
            end
            M_SCORE: begin
               if (e_res == 1) e_s1++;
               if (e_res == 2) e_s2++;
               if (e_s1 == WIN_SCORE || e_s2 == WIN_SCORE) e_mo = 1;
               m_ph = M_SHOW;
            end
            M_SHOW: begin
               if (next) begin
                  if (e_mo == 1) begin e_s1 = 0; e_s2 = 0; e_mo = 0; end
                  e_lk1 = 0; e_lk2 = 0; e_susp = 0; e_m1 = 0; e_m2 = 0;
                  m_ph = M_COLLECT;
               end
            end
            default: m_ph = M_COLLECT;
         endcase
         e_res = model_judge(old_m1, old_m2);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      if (chk_en && !rst) begin
         n_cmp++;
         if (int'(move1) != e_m1 || int'(move2) != e_m2 || int'(result) != e_res ||
             int'(susp_en) != e_susp || int'(score1) != e_s1 || int'(score2) != e_s2 ||
             int'(locked) != (e_lk2 * 2 + e_lk1) || int'(match_over) != e_mo) begin
            n_bad++;
            $display("FAIL cycle_cmp t=%0t got mv=%0d/%0d res=%0d en=%0d sc=%0d/%0d lk=%0d mo=%0d exp mv=%0d/%0d res=%0d en=%0d sc=%0d/%0d lk=%0d mo=%0d",
                     $time, move1, move2, result, susp_en, score1, score2, locked, match_over,
                     e_m1, e_m2, e_res, e_susp, e_s1, e_s2, e_lk2 * 2 + e_lk1, e_mo);
         end
      end
   end

   // ---------------- literal checks ----------------
   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic clear_in();
      lock1 = 1'b0; lock2 = 1'b0; next = 1'b0; tick = 1'b0;
   endtask

   task automatic do_lock(input int which, input logic [1:0] sw1, input logic [1:0] sw2);
      @(negedge clk);
      clear_in();
      sw_move1 = sw1;
      sw_move2 = sw2;
      if (which == 1 || which == 3) lock1 = 1'b1;
      if (which == 2 || which == 3) lock2 = 1'b1;
      @(negedge clk);
      clear_in();
   endtask

   task automatic wait_susp(input string name);
      int g;
      g = 0;
      while (susp_en !== 1'b1 && g < 10) begin
         @(negedge clk);
         g++;
      end
      check({name, "_susp_timeout"}, int'(susp_en === 1'b1), 1);
   endtask

   // Ticks through the reveal; optional noise on next/lock, optional next on the final tick.
   task automatic run_reveal(input bit noise, input bit hit_final);
      int g;
      g = 0;
      while (g < 20000) begin
         @(negedge clk);
         clear_in();
         if (m_ph != M_REVEAL) break;
         tick = ($urandom_range(0, 3) != 0);
         if (noise) begin
            next  = ($urandom_range(0, 9) == 0);
            lock1 = ($urandom_range(0, 9) == 0);
            lock2 = ($urandom_range(0, 9) == 0);
            sw_move1 = 2'($urandom_range(0, 3));
            sw_move2 = 2'($urandom_range(0, 3));
         end
         if (hit_final && m_ticks == REVEAL_TICKS - 1) begin
            tick = 1'b1;
            next = 1'b1;
         end
         g++;
      end
      check("reveal_timeout", int'(g < 20000), 1);
      g = 0;
      while (m_ph != M_SHOW && g < 5) begin
         @(negedge clk);
         clear_in();
         g++;
      end
      check("show_timeout", int'(susp_en === 1'b1 && m_ph == M_SHOW), 1);
   endtask

   task automatic do_next();
      @(negedge clk);
      clear_in();
      next = 1'b1;
      @(negedge clk);
      clear_in();
   endtask

   task automatic random_round();
      int g;
      g = 0;
      while (m_ph == M_COLLECT && g < 200) begin
         @(negedge clk);
         clear_in();
         sw_move1 = 2'($urandom_range(0, 3));
         sw_move2 = 2'($urandom_range(0, 3));
         lock1 = ($urandom_range(0, 3) == 0);
         lock2 = ($urandom_range(0, 3) == 0);
         next  = ($urandom_range(0, 7) == 0);
         tick  = ($urandom_range(0, 1) == 0);
         g++;
      end
      check("collect_timeout", int'(g < 200), 1);
      run_reveal(1'b1, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) begin
         @(negedge clk);
         clear_in();
         tick  = ($urandom_range(0, 1) == 0);
         lock1 = ($urandom_range(0, 1) == 0);
      end
      do_next();
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst = 1'b1;
      clear_in();
      sw_move1 = 2'b00;
      sw_move2 = 2'b00;
      repeat (2) @(negedge clk);
      check("reset_susp", int'(susp_en), 0);
      check("reset_result", int'(result), 0);
      check("reset_locked", int'(locked), 0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // Paper beats rock.
      do_lock(1, 2'b01, 2'b00);
      do_lock(2, 2'b01, 2'b00);
      wait_susp("s1");
      check("s1_result", int'(result), 1);
      check("s1_move1", int'(move1), 1);
      run_reveal(1'b0, 1'b0);
      check("s1_score1", int'(score1), 1);
      check("s1_score2", int'(score2), 0);
      do_next();
      check("s1_next_susp", int'(susp_en), 0);
      check("s1_next_locked", int'(locked), 0);

      // Simultaneous locks, scissors tie.
      do_lock(3, 2'b10, 2'b10);
      wait_susp("s2");
      check("s2_result", int'(result), 3);
      run_reveal(1'b0, 1'b0);
      check("s2_score1", int'(score1), 1);
      check("s2_score2", int'(score2), 0);
      do_next();

      // Invalid move locked; relock ignored.
      do_lock(1, 2'b11, 2'b00);
      do_lock(1, 2'b00, 2'b00);
      do_lock(2, 2'b00, 2'b01);
      wait_susp("s3");
      check("s3_move1", int'(move1), 3);
      check("s3_result", int'(result), 0);
      run_reveal(1'b0, 1'b0);
      check("s3_score1", int'(score1), 1);
      do_next();

      // Noise during reveal and next on the final tick.
      do_lock(3, 2'b00, 2'b10);
      wait_susp("s6");
      run_reveal(1'b1, 1'b1);
      repeat (3) @(negedge clk);
      check("s6_still_show", int'(susp_en), 1);
      check("s6_score1", int'(score1), 2);
      do_next();

      // Reset in the middle of the reveal.
      do_lock(3, 2'b01, 2'b00);
      wait_susp("s5");
      begin
         int g;
         g = 0;
         while (m_ticks < 800 && g < 5000) begin
            @(negedge clk);
            clear_in();
            tick = 1'b1;
            g++;
         end
         check("s5_tick_timeout", int'(g < 5000), 1);
      end
      clear_in();
      rst = 1'b1;
      #1;
      check("s5_rst_susp", int'(susp_en), 0);
      check("s5_rst_score1", int'(score1), 0);
      check("s5_rst_locked", int'(locked), 0);
      @(negedge clk);
      rst = 1'b0;
      do_lock(1, 2'b10, 2'b00);
      check("s5_collect_lock", int'(locked), 1);
      do_lock(2, 2'b10, 2'b00);
      wait_susp("s5b");
      run_reveal(1'b0, 1'b0);
      check("s5_score1_after", int'(score1), 0);
      check("s5_score2_after", int'(score2), 1);
      do_next();

      // Player 2 wins the match.
      repeat (2) begin
         do_lock(3, 2'b00, 2'b01);
         wait_susp("s4");
         run_reveal(1'b0, 1'b0);
         if (match_over !== 1'b1) do_next();
      end
      check("s4_score2", int'(score2), 3);
      check("s4_match_over", int'(match_over), 1);
      do_next();
      check("s4_clr_score2", int'(score2), 0);
      check("s4_clr_match", int'(match_over), 0);

      repeat (12) random_round();

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
